// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, PC source
// selects and trap causes.
package ctrl_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned PC_SEL_W  = 2;
    localparam int unsigned MCAUSE_W  = 4;
    localparam int unsigned CSR_OP_W  = 8;
    localparam int unsigned INSTRET_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [PC_SEL_W-1:0] PC_SEL_JUMP = 2'b01;
    localparam logic [PC_SEL_W-1:0] PC_SEL_TRAP = 2'b10;
    localparam logic [PC_SEL_W-1:0] PC_SEL_MEPC = 2'b11;

    localparam logic [MCAUSE_W-1:0] MCAUSE_IFAULT  = 4'd1;
    localparam logic [MCAUSE_W-1:0] MCAUSE_ILLEGAL = 4'd2;
    localparam logic [MCAUSE_W-1:0] MCAUSE_BREAK   = 4'd3;
    localparam logic [MCAUSE_W-1:0] MCAUSE_LFAULT  = 4'd5;
    localparam logic [MCAUSE_W-1:0] MCAUSE_SFAULT  = 4'd7;
    localparam logic [MCAUSE_W-1:0] MCAUSE_ECALL   = 4'd11;

endpackage

// File: rtl/mem_wdog.sv
// Memory-request watchdog: counts unacknowledged request cycles and flags
// when the count reaches TIMEOUT.
module mem_wdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/cycle_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with trap
// handling, memory watchdog and retired-instruction counter.
module cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_ack_n,
    input  logic                  inst_valid_n,
    input  logic                  load_n,
    input  logic                  store_n,
    input  logic                  gpr_we_n,
    input  logic [CSR_OP_W-1:0]   csr_op_n,
    input  logic                  jump_n,
    output logic                  mem_req_n,
    output logic                  mem_wr_n,
    output logic                  addr_sel,
    output logic                  ir_le_n,
    output logic                  pc_le_n,
    output logic [PC_SEL_W-1:0]   pc_sel,
    output logic                  gpr_wr_n,
    output logic                  csr_wr_n,
    output logic                  mepc_le_n,
    output logic [MCAUSE_W-1:0]   mcause,
    output logic [STATE_W-1:0]    state,
    output logic [INSTRET_W-1:0]  instret
);

    state_e                 state_q, state_d;
    logic [MCAUSE_W-1:0]    mcause_q, mcause_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   wdog_expired_c;
    logic                   req_state_c;
    logic                   unused_csr_bits;

    assign unused_csr_bits = csr_op_n[7] ^ csr_op_n[0];
    assign req_state_c     = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // Counter restarts on every state change, so it is zero on entry to FETCH/MEM.
    mem_wdog #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_d != state_q),
        .inc_i     (req_state_c && mem_ack_n),
        .expired_c (wdog_expired_c)
    );

    always_comb begin
        state_d   = state_q;
        mcause_d  = mcause_q;
        instret_d = instret_q;
        case (state_q)
            ST_FETCH: begin
                if (!mem_ack_n) begin
                    state_d = ST_DECODE;
                end else if (wdog_expired_c) begin
                    state_d  = ST_TRAP;
                    mcause_d = MCAUSE_IFAULT;
                end
            end
            ST_DECODE: begin
                if (inst_valid_n) begin
                    state_d  = ST_TRAP;
                    mcause_d = MCAUSE_ILLEGAL;
                end else if (!csr_op_n[6]) begin
                    state_d  = ST_TRAP;
                    mcause_d = MCAUSE_ECALL;
                end else if (!csr_op_n[5]) begin
                    state_d  = ST_TRAP;
                    mcause_d = MCAUSE_BREAK;
                end else if (!csr_op_n[4]) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = (!load_n || !store_n) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (!mem_ack_n) begin
                    state_d = ST_WB;
                end else if (wdog_expired_c) begin
                    state_d  = ST_TRAP;
                    mcause_d = store_n ? MCAUSE_LFAULT : MCAUSE_SFAULT;
                end
            end
            ST_WB: begin
                state_d   = ST_FETCH;
                instret_d = instret_q + INSTRET_W'(1);
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            mcause_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            mcause_q  <= mcause_d;
            instret_q <= instret_d;
        end
    end

    // Strobes are forced idle while reset is asserted so a pending request drops at once.
    always_comb begin
        mem_req_n = 1'b1;
        mem_wr_n  = 1'b1;
        addr_sel  = 1'b0;
        ir_le_n   = 1'b1;
        pc_le_n   = 1'b1;
        pc_sel    = PC_SEL_SEQ;
        gpr_wr_n  = 1'b1;
        csr_wr_n  = 1'b1;
        mepc_le_n = 1'b1;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req_n = 1'b0;
                    ir_le_n   = mem_ack_n;
                end
                ST_DECODE: begin
                    if (!inst_valid_n && csr_op_n[6] && csr_op_n[5] && !csr_op_n[4]) begin
                        pc_sel  = PC_SEL_MEPC;
                        pc_le_n = 1'b0;
                    end
                end
                ST_MEM: begin
                    mem_req_n = 1'b0;
                    addr_sel  = 1'b1;
                    mem_wr_n  = store_n;
                end
                ST_WB: begin
                    gpr_wr_n = gpr_we_n;
                    csr_wr_n = &csr_op_n[3:1];
                    pc_le_n  = 1'b0;
                    pc_sel   = jump_n ? PC_SEL_SEQ : PC_SEL_JUMP;
                end
                ST_TRAP: begin
                    mepc_le_n = 1'b0;
                    pc_le_n   = 1'b0;
                    pc_sel    = PC_SEL_TRAP;
                end
                default: begin
                end
            endcase
        end
    end

    assign state   = state_q;
    assign mcause  = mcause_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_cycle_ctrl.sv
// Bench for cycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle trace, which is then replayed against the DUT.
module tb_cycle_ctrl;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ack_n;
    logic        inst_valid_n;
    logic        load_n;
    logic        store_n;
    logic        gpr_we_n;
    logic [7:0]  csr_op_n;
    logic        jump_n;
    logic        mem_req_n;
    logic        mem_wr_n;
    logic        addr_sel;
    logic        ir_le_n;
    logic        pc_le_n;
    logic [1:0]  pc_sel;
    logic        gpr_wr_n;
    logic        csr_wr_n;
    logic        mepc_le_n;
    logic [3:0]  mcause;
    logic [2:0]  state;
    logic [31:0] instret;

    always #5 clk = ~clk;

    cycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_ack_n    (mem_ack_n),
        .inst_valid_n (inst_valid_n),
        .load_n       (load_n),
        .store_n      (store_n),
        .gpr_we_n     (gpr_we_n),
        .csr_op_n     (csr_op_n),
        .jump_n       (jump_n),
        .mem_req_n    (mem_req_n),
        .mem_wr_n     (mem_wr_n),
        .addr_sel     (addr_sel),
        .ir_le_n      (ir_le_n),
        .pc_le_n      (pc_le_n),
        .pc_sel       (pc_sel),
        .gpr_wr_n     (gpr_wr_n),
        .csr_wr_n     (csr_wr_n),
        .mepc_le_n    (mepc_le_n),
        .mcause       (mcause),
        .state        (state),
        .instret      (instret)
    );

    typedef struct packed {
        logic [2:0]  state;
        logic        mem_req_n;
        logic        mem_wr_n;
        logic        addr_sel;
        logic        ir_le_n;
        logic        pc_le_n;
        logic [1:0]  pc_sel;
        logic        gpr_wr_n;
        logic        csr_wr_n;
        logic        mepc_le_n;
        logic [3:0]  mcause;
        logic [31:0] instret;
    } out_t;

    typedef struct {
        string      tag;
        logic       ack_n;
        logic       iv_n;
        logic       ld_n;
        logic       st_n;
        logic       gwe_n;
        logic [7:0] csr;
        logic       jmp_n;
        out_t       exp;
    } rec_t;

    // fw/mw: wait cycles before ack in fetch/memory; > TMO means never acked
    typedef struct {
        string      name;
        logic       iv_n;
        logic       ld_n;
        logic       st_n;
        logic       gwe_n;
        logic [7:0] csr;
        logic       jmp_n;
        int         fw;
        int         mw;
    } instr_t;

    int          n_chk;
    int          n_fail;
    logic [31:0] m_instret;
    logic [3:0]  m_mcause;
    rec_t        q[$];
    instr_t      dir[16];

    function automatic out_t idle_out(input logic [2:0] st);
        out_t o;
        o.state     = st;
        o.mem_req_n = 1'b1;
        o.mem_wr_n  = 1'b1;
        o.addr_sel  = 1'b0;
        o.ir_le_n   = 1'b1;
        o.pc_le_n   = 1'b1;
        o.pc_sel    = 2'b00;
        o.gpr_wr_n  = 1'b1;
        o.csr_wr_n  = 1'b1;
        o.mepc_le_n = 1'b1;
        o.mcause    = m_mcause;
        o.instret   = m_instret;
        return o;
    endfunction

    function automatic out_t actual_out();
        out_t o;
        o.state     = state;
        o.mem_req_n = mem_req_n;
        o.mem_wr_n  = mem_wr_n;
        o.addr_sel  = addr_sel;
        o.ir_le_n   = ir_le_n;
        o.pc_le_n   = pc_le_n;
        o.pc_sel    = pc_sel;
        o.gpr_wr_n  = gpr_wr_n;
        o.csr_wr_n  = csr_wr_n;
        o.mepc_le_n = mepc_le_n;
        o.mcause    = mcause;
        o.instret   = instret;
        return o;
    endfunction

    function automatic instr_t mk(input string nm, input logic iv, input logic ld, input logic st,
                                  input logic gwe, input logic [7:0] csr, input logic jmp,
                                  input int fw, input int mw);
        instr_t t;
        t.name = nm; t.iv_n = iv; t.ld_n = ld; t.st_n = st; t.gwe_n = gwe;
        t.csr = csr; t.jmp_n = jmp; t.fw = fw; t.mw = mw;
        return t;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t a;
        a = actual_out();
        n_chk++;
        if (a !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got st=%0d req=%b wr=%b as=%b ir=%b pcle=%b pcsel=%b gpr=%b csr=%b mepc=%b mc=%0d ret=%0d | exp st=%0d req=%b wr=%b as=%b ir=%b pcle=%b pcsel=%b gpr=%b csr=%b mepc=%b mc=%0d ret=%0d",
                     name, $time, a.state, a.mem_req_n, a.mem_wr_n, a.addr_sel, a.ir_le_n, a.pc_le_n,
                     a.pc_sel, a.gpr_wr_n, a.csr_wr_n, a.mepc_le_n, a.mcause, a.instret,
                     exp.state, exp.mem_req_n, exp.mem_wr_n, exp.addr_sel, exp.ir_le_n, exp.pc_le_n,
                     exp.pc_sel, exp.gpr_wr_n, exp.csr_wr_n, exp.mepc_le_n, exp.mcause, exp.instret);
        end
    endtask

    // Memory phase: waits then ack, or a fault after TMO+1 unacked request cycles.
    task automatic gen_req(inout rec_t r, input logic [2:0] st, input int waits,
                           input logic as, input logic wr_n, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i <= TMO; i++) begin
            r.ack_n         = (i < waits);
            r.exp           = idle_out(st);
            r.exp.mem_req_n = 1'b0;
            r.exp.addr_sel  = as;
            r.exp.mem_wr_n  = wr_n;
            if (st == 3'd0) r.exp.ir_le_n = r.ack_n;
            q.push_back(r);
            if (!r.ack_n) break;
            if (i == TMO) timed_out = 1'b1;
        end
    endtask

    task automatic gen(input instr_t in);
        rec_t r;
        int   cause;
        bit   to;
        cause   = 0;
        r.tag   = in.name;
        r.iv_n  = in.iv_n;
        r.ld_n  = in.ld_n;
        r.st_n  = in.st_n;
        r.gwe_n = in.gwe_n;
        r.csr   = in.csr;
        r.jmp_n = in.jmp_n;
        gen_req(r, 3'd0, in.fw, 1'b0, 1'b1, to);
        if (to) cause = 1;
        if (cause == 0) begin
            r.ack_n = 1'($urandom_range(0, 1));
            r.exp   = idle_out(3'd1);
            if (in.iv_n) cause = 2;
            else if (!in.csr[6]) cause = 11;
            else if (!in.csr[5]) cause = 3;
            else if (!in.csr[4]) begin
                r.exp.pc_sel  = 2'b11;
                r.exp.pc_le_n = 1'b0;
                q.push_back(r);
                return;
            end
            q.push_back(r);
        end
        if (cause == 0) begin
            r.ack_n = 1'($urandom_range(0, 1));
            r.exp   = idle_out(3'd2);
            q.push_back(r);
            if (!in.ld_n || !in.st_n) begin
                gen_req(r, 3'd3, in.mw, 1'b1, in.st_n, to);
                if (to) cause = in.st_n ? 5 : 7;
            end
        end
        if (cause == 0) begin
            r.ack_n        = 1'($urandom_range(0, 1));
            r.exp          = idle_out(3'd4);
            r.exp.gpr_wr_n = in.gwe_n;
            r.exp.csr_wr_n = (in.csr[3:1] == 3'b111);
            r.exp.pc_le_n  = 1'b0;
            r.exp.pc_sel   = in.jmp_n ? 2'b00 : 2'b01;
            q.push_back(r);
            m_instret = m_instret + 32'd1;
            return;
        end
        m_mcause        = 4'(cause);
        r.ack_n         = 1'($urandom_range(0, 1));
        r.exp           = idle_out(3'd5);
        r.exp.mepc_le_n = 1'b0;
        r.exp.pc_le_n   = 1'b0;
        r.exp.pc_sel    = 2'b10;
        q.push_back(r);
    endtask

    // Replays up to n queued cycles (all when n < 0); entered and left at a negedge.
    task automatic play(input int n);
        rec_t r;
        int   k;
        k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            r            = q.pop_front();
            mem_ack_n    = r.ack_n;
            inst_valid_n = r.iv_n;
            load_n       = r.ld_n;
            store_n      = r.st_n;
            gpr_we_n     = r.gwe_n;
            csr_op_n     = r.csr;
            jump_n       = r.jmp_n;
            #1;
            check(r.tag, r.exp);
            @(negedge clk);
            k++;
        end
    endtask

    function automatic int rand_wait();
        int p;
        p = int'($urandom_range(0, 31));
        if (p == 0) return 99;
        if (p == 1) return TMO;
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        instr_t ri;
        out_t   e;
        int     sel;
        n_chk        = 0;
        n_fail       = 0;
        m_instret    = '0;
        m_mcause     = '0;
        rst_n        = 1'b0;
        mem_ack_n    = 1'b1;
        inst_valid_n = 1'b0;
        load_n       = 1'b1;
        store_n      = 1'b1;
        gpr_we_n     = 1'b1;
        csr_op_n     = 8'hFF;
        jump_n       = 1'b1;

        dir[0]  = mk("alu_ack0",      1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 0,  0);
        dir[1]  = mk("load_wait3",    1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 0,  3);
        dir[2]  = mk("store_timeout", 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 0,  99);
        dir[3]  = mk("illegal",       1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1,  0);
        dir[4]  = mk("ecall",         1'b0, 1'b1, 1'b1, 1'b1, 8'hBF, 1'b1, 0,  0);
        dir[5]  = mk("ebreak",        1'b0, 1'b1, 1'b1, 1'b1, 8'hDF, 1'b1, 0,  0);
        dir[6]  = mk("mret",          1'b0, 1'b1, 1'b1, 1'b1, 8'hEF, 1'b1, 2,  0);
        dir[7]  = mk("branch_taken",  1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 0,  0);
        dir[8]  = mk("branch_not",    1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 0,  0);
        dir[9]  = mk("csrrw",         1'b0, 1'b1, 1'b1, 1'b0, 8'hFD, 1'b1, 0,  0);
        dir[10] = mk("fetch_timeout", 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 99, 0);
        dir[11] = mk("fetch_ack_last",1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, TMO, 0);
        dir[12] = mk("load_ack_last", 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 0,  TMO);
        dir[13] = mk("load_timeout",  1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1,  99);
        dir[14] = mk("ecall_over_brk",1'b0, 1'b1, 1'b1, 1'b0, 8'h9F, 1'b1, 0,  0);
        dir[15] = mk("illegal_ecall", 1'b1, 1'b1, 1'b1, 1'b0, 8'hBF, 1'b1, 0,  0);

        @(negedge clk);
        #1;
        check("reset_idle", idle_out(3'd0));
        mem_ack_n = 1'b0;
        #1;
        check("reset_ack_no_ir", idle_out(3'd0));
        mem_ack_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            gen(dir[i]);
            play(-1);
        end

        // Reset pulse while a load is waiting in MEM
        gen(mk("load_rst", 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 10));
        play(5);
        q.delete();
        rst_n     = 1'b0;
        m_instret = '0;
        m_mcause  = '0;
        #1;
        check("rst_mid_mem", idle_out(3'd0));
        @(negedge clk);
        mem_ack_n = 1'b1;
        rst_n     = 1'b1;
        #1;
        e           = idle_out(3'd0);
        e.mem_req_n = 1'b0;
        check("post_reset_fetch", e);

        for (int n = 0; n < 300; n++) begin
            ri.name  = "random";
            ri.iv_n  = ($urandom_range(0, 9) == 0);
            ri.csr   = 8'($urandom);
            ri.csr[6] = ($urandom_range(0, 7) != 0);
            ri.csr[5] = ($urandom_range(0, 7) != 0);
            ri.csr[4] = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 0) ri.csr[3:1] = 3'b111;
            sel      = int'($urandom_range(0, 2));
            ri.ld_n  = (sel != 1);
            ri.st_n  = (sel != 2);
            ri.gwe_n = 1'($urandom_range(0, 1));
            ri.jmp_n = 1'($urandom_range(0, 1));
            ri.fw    = rand_wait();
            ri.mw    = rand_wait();
            gen(ri);
            play(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
